// File: rtl/imem_loader.sv
// imem_loader: loads a length-prefixed, big-endian byte stream into instruction memory
// and holds the processor in reset until the load completes.
// Stream format: count[15:8], count[7:0], then count words of 4 bytes each (MSB first).
// Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.

module imem_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [7:0]  i_byte_in,
  input  logic        i_byte_valid,
  output logic        o_byte_ready,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic        o_cpu_rst,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error
);

  // Memory capacity in words; 33 bits so any ADDR_W up to 32 is representable.
  localparam logic [32:0] Cap = 33'd1 << ADDR_W;

  typedef enum logic [2:0] {
    StIdle, StHdrHi, StHdrLo, StData, StWrite, StChk, StDone
  } state_e;

  state_e      r_state;
  state_e      w_state_d;
  logic [7:0]  r_hdr_hi;
  logic [15:0] r_count;
  logic [15:0] r_index;
  logic [1:0]  r_byte_cnt;
  logic [23:0] r_word;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic        r_done;
  logic        r_error;

  logic        w_xfer;
  logic        w_start_ok;
  logic [15:0] w_hdr_count;
  logic        w_hdr_over;
  logic        w_in_range;
  logic        w_last_word;

  assign w_xfer      = i_byte_valid && o_byte_ready;
  assign w_start_ok  = i_start && ((r_state == StIdle) || (r_state == StDone));
  assign w_hdr_count = {r_hdr_hi, i_byte_in};
  assign w_hdr_over  = ({17'd0, w_hdr_count} > Cap);
  // Words past capacity are consumed but never written, so the address never wraps.
  assign w_in_range  = ({17'd0, r_index} < Cap);
  assign w_last_word = (({1'b0, r_index} + 17'd1) == {1'b0, r_count});

  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_done      = r_done;
  assign o_error     = r_error;

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic and state-decoded outputs
  always_comb begin
    w_state_d    = r_state;
    o_byte_ready = 1'b0;
    o_mem_we     = 1'b0;
    o_busy       = 1'b1;
    o_cpu_rst    = 1'b1;
    case (r_state)
      StIdle: begin
        o_busy = 1'b0;
        if (i_start) w_state_d = StHdrHi;
      end
      StHdrHi: begin
        o_byte_ready = 1'b1;
        if (w_xfer) w_state_d = StHdrLo;
      end
      StHdrLo: begin
        o_byte_ready = 1'b1;
        if (w_xfer) w_state_d = (w_hdr_count == 16'd0) ? StDone : StData;
      end
      StData: begin
        o_byte_ready = 1'b1;
        if (w_xfer && (r_byte_cnt == 2'd3)) w_state_d = StWrite;
      end
      StWrite: begin
        o_mem_we = w_in_range;
        if (w_last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          w_state_d = StChk;
`else
          w_state_d = StDone;
`endif
        end else begin
          w_state_d = StData;
        end
      end
      StChk: begin
        o_byte_ready = 1'b1;
        if (w_xfer) w_state_d = StDone;
      end
      StDone: begin
        o_busy    = 1'b0;
        o_cpu_rst = 1'b0;
        if (i_start) w_state_d = StHdrHi;
      end
      default: w_state_d = StIdle;
    endcase
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] r_csum;

  // Running XOR of every header and data byte
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_csum <= 8'h00;
    end else if (w_start_ok) begin
      r_csum <= 8'h00;
    end else if (w_xfer && (r_state != StChk)) begin
      r_csum <= r_csum ^ i_byte_in;
    end
  end
`endif

  // Datapath: header capture, word assembly, write address/data, status flags
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hdr_hi    <= 8'h00;
      r_count     <= 16'd0;
      r_index     <= 16'd0;
      r_byte_cnt  <= 2'd0;
      r_word      <= 24'd0;
      r_mem_addr  <= BASE_ADDR;
      r_mem_wdata <= 32'd0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      // High only in the first cycle spent in DONE.
      r_done <= (w_state_d == StDone) && (r_state != StDone);
      case (r_state)
        StIdle, StDone: begin
          if (i_start) begin
            r_error    <= 1'b0;
            r_index    <= 16'd0;
            r_byte_cnt <= 2'd0;
          end
        end
        StHdrHi: begin
          if (w_xfer) r_hdr_hi <= i_byte_in;
        end
        StHdrLo: begin
          if (w_xfer) begin
            r_count <= w_hdr_count;
            if (w_hdr_over) r_error <= 1'b1;
          end
        end
        StData: begin
          if (w_xfer) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            r_word     <= {r_word[15:0], i_byte_in};
            if ((r_byte_cnt == 2'd3) && w_in_range) begin
              r_mem_addr  <= BASE_ADDR + {14'd0, r_index, 2'b00};
              r_mem_wdata <= {r_word, i_byte_in};
            end
          end
        end
        StWrite: begin
          r_index <= r_index + 16'd1;
        end
        StChk: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (w_xfer && (i_byte_in != r_csum)) r_error <= 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader. Two instances share one stimulus stream:
// u_dut_a (ADDR_W=8) and u_dut_b (ADDR_W=2, capacity 4 words) so capacity overflow is
// exercised alongside normal loads. Build with +define+IMEM_LOADER_CHECKSUM_EN to cover
// the checksum variant.

module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_in;

  logic        a_ready, a_we, a_cpu_rst, a_busy, a_done, a_error;
  logic [31:0] a_addr, a_wdata;
  logic        b_ready, b_we, b_cpu_rst, b_busy, b_done, b_error;
  logic [31:0] b_addr, b_wdata;

  imem_loader #(.ADDR_W(8), .BASE_ADDR(32'h0000_0000)) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_byte_in(byte_in),
    .i_byte_valid(byte_valid), .o_byte_ready(a_ready), .o_mem_we(a_we),
    .o_mem_addr(a_addr), .o_mem_wdata(a_wdata), .o_cpu_rst(a_cpu_rst),
    .o_busy(a_busy), .o_done(a_done), .o_error(a_error)
  );

  imem_loader #(.ADDR_W(2), .BASE_ADDR(32'h0000_0000)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_byte_in(byte_in),
    .i_byte_valid(byte_valid), .o_byte_ready(b_ready), .o_mem_we(b_we),
    .o_mem_addr(b_addr), .o_mem_wdata(b_wdata), .o_cpu_rst(b_cpu_rst),
    .o_busy(b_busy), .o_done(b_done), .o_error(b_error)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  always @(posedge clk) cycle <= cycle + 1;

  // Observed writes ({addr, data}) and done pulses, sampled mid-cycle.
  logic [63:0] wr_a[$];
  logic [63:0] wr_b[$];
  int          stamp_a[$];
  int          done_a = 0;
  int          done_b = 0;
  logic        cpu_rst_at_done = 1'b1;

  always @(negedge clk) begin
    if (a_we) begin
      wr_a.push_back({a_addr, a_wdata});
      stamp_a.push_back(cycle);
    end
    if (b_we) wr_b.push_back({b_addr, b_wdata});
    if (a_done) begin
      done_a++;
      cpu_rst_at_done = a_cpu_rst;
    end
    if (b_done) done_b++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  logic [7:0]  stim[$];
  logic [63:0] exp_q[$];

  function automatic void append_csum(input bit bad);
    logic [7:0] x;
    x = 8'h00;
    foreach (stim[i]) x = x ^ stim[i];
    x = bad ? ~x : x;
`ifdef IMEM_LOADER_CHECKSUM_EN
    stim.push_back(x);
`endif
  endfunction

  function automatic void make_stream(input int unsigned count);
    stim.delete();
    stim.push_back(count[15:8]);
    stim.push_back(count[7:0]);
    for (int unsigned i = 0; i < 4 * count; i++) stim.push_back(8'($urandom));
    append_csum(1'b0);
  endfunction

  // Expected writes: word i goes to byte address 4*i only while i is below capacity.
  function automatic void build_expected(input int unsigned cap);
    int unsigned n;
    n = {stim[0], stim[1]};
    exp_q.delete();
    for (int unsigned i = 0; i < n && i < cap; i++)
      exp_q.push_back({32'(4 * i), stim[2 + 4 * i], stim[3 + 4 * i],
                       stim[4 + 4 * i], stim[5 + 4 * i]});
  endfunction

  function automatic bit expected_error(input int unsigned cap);
    int unsigned n;
    bit          e;
    logic [7:0]  x;
    n = {stim[0], stim[1]};
    e = (n > cap);
`ifdef IMEM_LOADER_CHECKSUM_EN
    x = 8'h00;
    for (int i = 0; i < stim.size() - 1; i++) x = x ^ stim[i];
    if (x != stim[stim.size() - 1]) e = 1'b1;
`else
    x = 8'h00;
`endif
    return e;
  endfunction

  // ---------------- drivers ----------------
  task automatic clear_mon();
    wr_a.delete();
    wr_b.delete();
    stamp_a.delete();
    done_a = 0;
    done_b = 0;
    cpu_rst_at_done = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
    ok = 1'b0;
    byte_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    byte_in    = b;
    byte_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      if (a_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    for (int t = 0; t < 20 && done_a == 0; t++) begin @(posedge clk); #1; end
    ok = (done_a != 0);
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic do_load(input int gmin, input int gmax, input int start_at, output bit ok);
    bit sent;
    bit fin;
    ok = 1'b1;
    clear_mon();
    pulse_start();
    for (int i = 0; i < stim.size(); i++) begin
      if (i == start_at) pulse_start();
      send_byte(stim[i], int'($urandom_range(gmax, gmin)), sent);
      if (!sent) ok = 1'b0;
    end
    wait_done(fin);
    if (!fin) ok = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    repeat (2) begin @(posedge clk); #1; end
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b, expected 0", a_ready); end
    checks++; if (a_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b, expected 0", a_we); end
    checks++; if (a_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h, expected 0", a_addr); end
    checks++; if (a_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h, expected 0", a_wdata); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", a_busy); end
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, expected 0", a_done); end
    checks++; if (a_error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b, expected 0", a_error); end
    checks++; if (a_cpu_rst !== 1'b1) begin errors++; $display("FAIL reset_cpu_rst: got %b, expected 1", a_cpu_rst); end
    rst = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    checks++; if (a_cpu_rst !== 1'b1) begin errors++; $display("FAIL idle_cpu_rst: got %b, expected 1", a_cpu_rst); end
  endtask

  task automatic basic_stream();
    stim.delete();
    stim = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h01, 8'h00, 8'h04};
    append_csum(1'b0);
  endtask

  task automatic check_basic(input string tag, input bit ok);
    checks++; if (!ok) begin errors++; $display("FAIL %s_handshake: got timeout, expected done", tag); end
    checks++; if (wr_a.size() != 2) begin errors++; $display("FAIL %s_nwrites: got %0d, expected 2", tag, wr_a.size()); end
    if (wr_a.size() == 2) begin
      checks++; if (wr_a[0] !== 64'h00000000_20080005) begin errors++; $display("FAIL %s_w0: got %h, expected 0000000020080005", tag, wr_a[0]); end
      checks++; if (wr_a[1] !== 64'h00000004_AC010004) begin errors++; $display("FAIL %s_w1: got %h, expected 00000004ac010004", tag, wr_a[1]); end
    end
    checks++; if (done_a != 1) begin errors++; $display("FAIL %s_done: got %0d pulses, expected 1", tag, done_a); end
    checks++; if (a_error !== 1'b0) begin errors++; $display("FAIL %s_error: got %b, expected 0", tag, a_error); end
    checks++; if (cpu_rst_at_done !== 1'b0) begin errors++; $display("FAIL %s_cpu_rst_done: got %b, expected 0", tag, cpu_rst_at_done); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL %s_busy: got %b, expected 0", tag, a_busy); end
  endtask

  task automatic test_basic();
    bit ok;
    basic_stream();
    do_load(0, 0, -1, ok);
    check_basic("basic", ok);
  endtask

  task automatic test_gaps();
    bit ok;
    basic_stream();
    do_load(3, 3, -1, ok);
    check_basic("gaps", ok);
  endtask

  task automatic test_overflow();
    bit ok;
    bit sent;
    make_stream(5);
    clear_mon();
    pulse_start();
    ok = 1'b1;
    for (int i = 0; i < 2; i++) begin send_byte(stim[i], 0, sent); if (!sent) ok = 1'b0; end
    checks++; if (b_error !== 1'b1) begin errors++; $display("FAIL ovf_hdr_error_b: got %b, expected 1", b_error); end
    checks++; if (a_error !== 1'b0) begin errors++; $display("FAIL ovf_hdr_error_a: got %b, expected 0", a_error); end
    for (int i = 2; i < stim.size(); i++) begin
      send_byte(stim[i], int'($urandom_range(1, 0)), sent);
      if (!sent) ok = 1'b0;
    end
    wait_done(sent);
    checks++; if (!(ok && sent)) begin errors++; $display("FAIL ovf_handshake: got timeout, expected done"); end
    build_expected(4);
    checks++; if (wr_b.size() != 4) begin errors++; $display("FAIL ovf_nwrites_b: got %0d, expected 4", wr_b.size()); end
    foreach (exp_q[i]) if (i < wr_b.size()) begin
      checks++; if (wr_b[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_w%0d_b: got %h, expected %h", i, wr_b[i], exp_q[i]); end
    end
    build_expected(256);
    checks++; if (wr_a.size() != 5) begin errors++; $display("FAIL ovf_nwrites_a: got %0d, expected 5", wr_a.size()); end
    checks++; if (done_b != 1) begin errors++; $display("FAIL ovf_done_b: got %0d, expected 1", done_b); end
    checks++; if (b_error !== expected_error(4)) begin errors++; $display("FAIL ovf_final_error_b: got %b, expected 1", b_error); end
  endtask

  task automatic test_reset_midload();
    bit ok;
    bit sent;
    make_stream(1);
    clear_mon();
    pulse_start();
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin send_byte(stim[i], 0, sent); if (!sent) ok = 1'b0; end
    rst = 1'b1;
    #1;
    checks++; if (!ok) begin errors++; $display("FAIL mid_handshake: got timeout, expected accept"); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b, expected 0", a_busy); end
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL mid_ready: got %b, expected 0", a_ready); end
    checks++; if (a_cpu_rst !== 1'b1) begin errors++; $display("FAIL mid_cpu_rst: got %b, expected 1", a_cpu_rst); end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    checks++; if (wr_a.size() != 0) begin errors++; $display("FAIL mid_no_write: got %0d writes, expected 0", wr_a.size()); end
    make_stream(1);
    do_load(0, 1, -1, ok);
    build_expected(256);
    checks++; if (!ok) begin errors++; $display("FAIL mid_reload_handshake: got timeout, expected done"); end
    checks++; if (wr_a.size() != 1) begin errors++; $display("FAIL mid_reload_n: got %0d, expected 1", wr_a.size()); end
    if (wr_a.size() == 1) begin
      checks++; if (wr_a[0] !== exp_q[0]) begin errors++; $display("FAIL mid_reload_w0: got %h, expected %h", wr_a[0], exp_q[0]); end
    end
  endtask

  task automatic test_start_ignored();
    bit ok;
    make_stream(3);
    do_load(0, 1, 4, ok);
    build_expected(256);
    checks++; if (!ok) begin errors++; $display("FAIL startign_handshake: got timeout, expected done"); end
    checks++; if (wr_a.size() != 3) begin errors++; $display("FAIL startign_n: got %0d, expected 3", wr_a.size()); end
    foreach (exp_q[i]) if (i < wr_a.size()) begin
      checks++; if (wr_a[i] !== exp_q[i]) begin errors++; $display("FAIL startign_w%0d: got %h, expected %h", i, wr_a[i], exp_q[i]); end
    end
    checks++; if (done_a != 1) begin errors++; $display("FAIL startign_done: got %0d, expected 1", done_a); end
  endtask

  task automatic test_zero_count();
    bit ok;
    stim.delete();
    stim = '{8'h00, 8'h00};
    do_load(0, 0, -1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL zero_handshake: got timeout, expected done"); end
    checks++; if (wr_a.size() != 0) begin errors++; $display("FAIL zero_writes: got %0d, expected 0", wr_a.size()); end
    checks++; if (done_a != 1) begin errors++; $display("FAIL zero_done: got %0d, expected 1", done_a); end
    checks++; if (a_cpu_rst !== 1'b0) begin errors++; $display("FAIL zero_cpu_rst: got %b, expected 0", a_cpu_rst); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    make_stream(4);
    do_load(0, 0, -1, ok);
    build_expected(256);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_handshake: got timeout, expected done"); end
    checks++; if (wr_a.size() != 4) begin errors++; $display("FAIL b2b_n: got %0d, expected 4", wr_a.size()); end
    for (int i = 1; i < stamp_a.size(); i++) begin
      checks++;
      if (stamp_a[i] - stamp_a[i-1] != 5) begin
        errors++; $display("FAIL b2b_spacing%0d: got %0d cycles, expected 5", i, stamp_a[i] - stamp_a[i-1]);
      end
    end
    foreach (exp_q[i]) if (i < wr_a.size()) begin
      checks++; if (wr_a[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_w%0d: got %h, expected %h", i, wr_a[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    bit ok;
    for (int it = 0; it < 6; it++) begin
      make_stream($urandom_range(6, 1));
      do_load(0, 2, -1, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rnd%0d_handshake: got timeout, expected done", it); end
      build_expected(256);
      checks++; if (wr_a.size() != exp_q.size()) begin errors++; $display("FAIL rnd%0d_n_a: got %0d, expected %0d", it, wr_a.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < wr_a.size()) begin
        checks++; if (wr_a[i] !== exp_q[i]) begin errors++; $display("FAIL rnd%0d_w%0d_a: got %h, expected %h", it, i, wr_a[i], exp_q[i]); end
      end
      checks++; if (a_error !== expected_error(256)) begin errors++; $display("FAIL rnd%0d_err_a: got %b, expected %b", it, a_error, expected_error(256)); end
      build_expected(4);
      checks++; if (wr_b.size() != exp_q.size()) begin errors++; $display("FAIL rnd%0d_n_b: got %0d, expected %0d", it, wr_b.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < wr_b.size()) begin
        checks++; if (wr_b[i] !== exp_q[i]) begin errors++; $display("FAIL rnd%0d_w%0d_b: got %h, expected %h", it, i, wr_b[i], exp_q[i]); end
      end
      checks++; if (b_error !== expected_error(4)) begin errors++; $display("FAIL rnd%0d_err_b: got %b, expected %b", it, b_error, expected_error(4)); end
      checks++; if (done_b != 1) begin errors++; $display("FAIL rnd%0d_done_b: got %0d, expected 1", it, done_b); end
    end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    bit ok;
    stim.delete();
    stim = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
    do_load(0, 1, -1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL csum_good_handshake: got timeout, expected done"); end
    checks++; if (a_error !== 1'b0) begin errors++; $display("FAIL csum_good_error: got %b, expected 0", a_error); end
    checks++; if (wr_a.size() != 1 || wr_a[0] !== 64'h00000000_12345678) begin
      errors++; $display("FAIL csum_good_write: got %0d writes, expected one write of 12345678 at 0", wr_a.size());
    end
    stim[6] = 8'h00;
    do_load(0, 1, -1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL csum_bad_handshake: got timeout, expected done"); end
    checks++; if (a_error !== 1'b1) begin errors++; $display("FAIL csum_bad_error: got %b, expected 1", a_error); end
    checks++; if (done_a != 1) begin errors++; $display("FAIL csum_bad_done: got %0d, expected 1", done_a); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_overflow();
    test_reset_midload();
    test_start_ignored();
    test_zero_count();
    test_back_to_back();
    test_random();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
